// File: rtl/rx_udp_payload_extractor.sv
// rx_udp_payload_extractor: pops beats from the RX CDC FIFO, parses the
// Ethernet/IPv4/UDP header in flight and streams only the UDP payload of
// frames addressed to UDP_PORT. Cut-through with a one-byte hold register so
// the final payload byte can carry tlast/tuser once the frame end is known.
// Optional feature: define RX_MAC_FILTER_EN to also filter on destination MAC
// (LOCAL_MAC, multicast or broadcast accepted).
module rx_udp_payload_extractor #(
    parameter logic [15:0] UDP_PORT  = 16'd14310,
    parameter logic [47:0] LOCAL_MAC = 48'h02_00_00_00_00_01
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [9:0] fifo_dout,
    input  logic       fifo_dout_valid,
    input  logic       fifo_empty,
    output logic       fifo_rd_en,
    output logic [7:0] m_axis_tdata,
    output logic       m_axis_tvalid,
    output logic       m_axis_tlast,
    output logic       m_axis_tuser,
    output logic       frame_drop
);

    localparam int unsigned CNT_W = 11;
    localparam int unsigned REM_W = 16;

    localparam logic [CNT_W-1:0] CNT_MAX      = '1;
    localparam logic [CNT_W-1:0] IDX_MAC_LAST = CNT_W'(5);
    localparam logic [CNT_W-1:0] IDX_ETYPE_LO = CNT_W'(13);
    localparam logic [CNT_W-1:0] IDX_VER_IHL  = CNT_W'(14);
    localparam logic [CNT_W-1:0] IDX_FRAG_LO  = CNT_W'(21);
    localparam logic [CNT_W-1:0] IDX_PROTO    = CNT_W'(23);
    localparam logic [CNT_W-1:0] IDX_DPORT_LO = CNT_W'(37);
    localparam logic [CNT_W-1:0] IDX_ULEN_LO  = CNT_W'(39);
    localparam logic [CNT_W-1:0] IDX_HDR_LAST = CNT_W'(41);

    typedef enum logic [1:0] {
        S_HDR     = 2'd0,
        S_PAYLOAD = 2'd1,
        S_PAD     = 2'd2,
        S_DROP    = 2'd3
    } state_t;

    state_t           state, state_nxt;
    logic [CNT_W-1:0] byte_cnt, byte_cnt_nxt;
    logic [7:0]       prev_byte, prev_byte_nxt;
    logic [REM_W-1:0] remaining, remaining_nxt;
    logic [7:0]       hold_data, hold_data_nxt;
    logic             hold_vld, hold_vld_nxt;
    logic             flush_pend, flush_pend_nxt;
    logic [7:0]       flush_data, flush_data_nxt;
    logic             flush_user, flush_user_nxt;
    logic [7:0]       tdata_nxt;
    logic             tvalid_nxt, tlast_nxt, tuser_nxt, drop_nxt;
    logic             hdr_bad;

    logic [7:0] din_data;
    logic       din_last;
    logic       din_user;

    assign din_data   = fifo_dout[7:0];
    assign din_last   = fifo_dout[8];
    assign din_user   = fifo_dout[9];

    // The block never stalls: pop whenever the FIFO has data
    assign fifo_rd_en = ~fifo_empty;

`ifdef RX_MAC_FILTER_EN
    logic [7:0] mac_byte;
    logic       mac_ok;
    logic       mcast;

    // Station MAC byte expected at the current destination-address position
    always_comb begin
        mac_byte = 8'h00;
        case (byte_cnt)
            CNT_W'(0): mac_byte = LOCAL_MAC[47:40];
            CNT_W'(1): mac_byte = LOCAL_MAC[39:32];
            CNT_W'(2): mac_byte = LOCAL_MAC[31:24];
            CNT_W'(3): mac_byte = LOCAL_MAC[23:16];
            CNT_W'(4): mac_byte = LOCAL_MAC[15:8];
            CNT_W'(5): mac_byte = LOCAL_MAC[7:0];
            default:   mac_byte = 8'h00;
        endcase
    end

    // Accumulate destination MAC match over bytes 0-4; byte 5 is judged inline
    always_ff @(posedge clk) begin
        if (rst) begin
            mac_ok <= 1'b0;
            mcast  <= 1'b0;
        end else if (fifo_dout_valid && (state == S_HDR)) begin
            if (byte_cnt == CNT_W'(0)) begin
                mac_ok <= (din_data == mac_byte);
                mcast  <= din_data[0];
            end else if (byte_cnt < IDX_MAC_LAST) begin
                mac_ok <= mac_ok && (din_data == mac_byte);
            end
        end
    end
`else
    logic unused_local_mac;
    assign unused_local_mac = ^LOCAL_MAC;
`endif

    // Header field check for the byte currently presented
    always_comb begin
        hdr_bad = 1'b0;
        case (byte_cnt)
`ifdef RX_MAC_FILTER_EN
            IDX_MAC_LAST: hdr_bad = !(mcast || (mac_ok && (din_data == mac_byte)));
`endif
            IDX_ETYPE_LO: hdr_bad = ({prev_byte, din_data} != 16'h0800);
            IDX_VER_IHL:  hdr_bad = (din_data != 8'h45);
            IDX_FRAG_LO:  hdr_bad = ((prev_byte & 8'h3F) != 8'h00) || (din_data != 8'h00);
            IDX_PROTO:    hdr_bad = (din_data != 8'h11);
            IDX_DPORT_LO: hdr_bad = ({prev_byte, din_data} != UDP_PORT);
            IDX_ULEN_LO:  hdr_bad = ({prev_byte, din_data} < 16'd9);
            default:      hdr_bad = 1'b0;
        endcase
    end

    // Next-state, hold/flush bookkeeping and next output values
    always_comb begin
        state_nxt      = state;
        byte_cnt_nxt   = byte_cnt;
        prev_byte_nxt  = prev_byte;
        remaining_nxt  = remaining;
        hold_data_nxt  = hold_data;
        hold_vld_nxt   = hold_vld;
        flush_pend_nxt = 1'b0;
        flush_data_nxt = flush_data;
        flush_user_nxt = flush_user;
        tdata_nxt      = 8'h00;
        tvalid_nxt     = 1'b0;
        tlast_nxt      = 1'b0;
        tuser_nxt      = 1'b0;
        drop_nxt       = 1'b0;

        // Final byte of a datagram that ended in PAYLOAD goes out one cycle late;
        // the next frame is still in its header, so nothing else is emitted now
        if (flush_pend) begin
            tvalid_nxt = 1'b1;
            tdata_nxt  = flush_data;
            tlast_nxt  = 1'b1;
            tuser_nxt  = flush_user;
        end

        if (fifo_dout_valid) begin
            prev_byte_nxt = din_data;
            if (din_last) begin
                byte_cnt_nxt = '0;
            end else if (byte_cnt != CNT_MAX) begin
                byte_cnt_nxt = byte_cnt + CNT_W'(1);
            end

            case (state)
                S_HDR: begin
                    if (byte_cnt == IDX_ULEN_LO) begin
                        remaining_nxt = {prev_byte, din_data} - REM_W'(8);
                    end
                    if (din_last) begin
                        drop_nxt = 1'b1;
                    end else if (hdr_bad) begin
                        state_nxt = S_DROP;
                    end else if (byte_cnt == IDX_HDR_LAST) begin
                        state_nxt = S_PAYLOAD;
                    end
                end
                S_PAYLOAD: begin
                    if (hold_vld) begin
                        tvalid_nxt = 1'b1;
                        tdata_nxt  = hold_data;
                    end
                    remaining_nxt = remaining - REM_W'(1);
                    if (din_last) begin
                        flush_pend_nxt = 1'b1;
                        flush_data_nxt = din_data;
                        flush_user_nxt = din_user || (remaining != REM_W'(1));
                        hold_vld_nxt   = 1'b0;
                        state_nxt      = S_HDR;
                    end else begin
                        hold_data_nxt = din_data;
                        hold_vld_nxt  = 1'b1;
                        if (remaining == REM_W'(1)) begin
                            state_nxt = S_PAD;
                        end
                    end
                end
                S_PAD: begin
                    if (din_last) begin
                        tvalid_nxt   = 1'b1;
                        tdata_nxt    = hold_data;
                        tlast_nxt    = 1'b1;
                        tuser_nxt    = din_user;
                        hold_vld_nxt = 1'b0;
                        state_nxt    = S_HDR;
                    end
                end
                S_DROP: begin
                    if (din_last) begin
                        drop_nxt  = 1'b1;
                        state_nxt = S_HDR;
                    end
                end
                default: state_nxt = S_HDR;
            endcase
        end
    end

    // State, datapath and output registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= S_HDR;
            byte_cnt      <= '0;
            prev_byte     <= 8'h00;
            remaining     <= '0;
            hold_data     <= 8'h00;
            hold_vld      <= 1'b0;
            flush_pend    <= 1'b0;
            flush_data    <= 8'h00;
            flush_user    <= 1'b0;
            m_axis_tdata  <= 8'h00;
            m_axis_tvalid <= 1'b0;
            m_axis_tlast  <= 1'b0;
            m_axis_tuser  <= 1'b0;
            frame_drop    <= 1'b0;
        end else begin
            state         <= state_nxt;
            byte_cnt      <= byte_cnt_nxt;
            prev_byte     <= prev_byte_nxt;
            remaining     <= remaining_nxt;
            hold_data     <= hold_data_nxt;
            hold_vld      <= hold_vld_nxt;
            flush_pend    <= flush_pend_nxt;
            flush_data    <= flush_data_nxt;
            flush_user    <= flush_user_nxt;
            m_axis_tdata  <= tdata_nxt;
            m_axis_tvalid <= tvalid_nxt;
            m_axis_tlast  <= tlast_nxt;
            m_axis_tuser  <= tuser_nxt;
            frame_drop    <= drop_nxt;
        end
    end

endmodule
